// File: rtl/pipe_perf_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_pkg
// Description : Shared types and default sizes for the pipeline perf/trace
//               monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_perf_pkg;

    localparam int TRACE_W        = 69;
    localparam int DEF_COUNT_W    = 32;
    localparam int DEF_FIFO_DEPTH = 8;
    localparam int DEF_DROP_W     = 16;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } trace_entry_t;

endpackage
`default_nettype wire

// File: rtl/perf_trace_fifo.sv
`default_nettype none
// ============================================================================
// Module      : perf_trace_fifo
// Description : Synchronous first-word-fall-through FIFO with occupancy level.
// Revision    : 1.0 - initial release
// ============================================================================
module perf_trace_fifo
    import pipe_perf_pkg::*;
#(
    parameter int WIDTH = TRACE_W,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int          AW           = $clog2(DEPTH);
    localparam logic [AW:0] c_full_level = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_level == '0);
    assign full  = (r_level == c_full_level);
    assign level = r_level;

    // A pop frees the slot a simultaneous push needs, so full+pop still accepts.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_perf_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : pipe_perf_trace_monitor
// Description : Passive pipeline observer: performance counters plus a trace
//               FIFO of architectural register writes.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_perf_trace_monitor
    import pipe_perf_pkg::*;
#(
    parameter int COUNT_W    = DEF_COUNT_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int DROP_W     = DEF_DROP_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic                          stall_f,
    input  logic                          stall_d,
    input  logic                          flush_d,
    input  logic                          flush_e,
    input  logic                          wb_valid,
    input  logic                          wb_regwrite,
    input  logic [4:0]                    wb_rd,
    input  logic [31:0]                   wb_data,
    input  logic [31:0]                   wb_pc,
    output logic [COUNT_W-1:0]            cycle_count,
    output logic [COUNT_W-1:0]            instret_count,
    output logic [COUNT_W-1:0]            stall_count,
    output logic [COUNT_W-1:0]            flush_count,
    output logic                          trace_valid,
    input  logic                          trace_ready,
    output logic [31:0]                   trace_pc,
    output logic [4:0]                    trace_rd,
    output logic [31:0]                   trace_data,
    output logic [$clog2(FIFO_DEPTH):0]   trace_level,
    output logic                          overflow,
    output logic [DROP_W-1:0]             drop_count
);

    logic [COUNT_W-1:0] r_cycle_count;
    logic [COUNT_W-1:0] r_instret_count;
    logic [COUNT_W-1:0] r_stall_count;
    logic [COUNT_W-1:0] r_flush_count;
    logic               r_overflow;
    logic [DROP_W-1:0]  r_drop_count;

    logic               w_fifo_rst;
    logic               w_push_req;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic               w_drop;
    trace_entry_t       w_din;
    trace_entry_t       w_head;

    // clear behaves exactly like reset, FIFO included.
    assign w_fifo_rst = rst | clear;
    assign w_push_req = enable & wb_valid & wb_regwrite & (wb_rd != 5'd0);
    assign w_pop      = trace_valid & trace_ready;
    assign w_drop     = w_push_req & w_full & ~w_pop;

    assign w_din = '{pc: wb_pc, rd: wb_rd, data: wb_data};

    perf_trace_fifo #(
        .WIDTH (TRACE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (w_fifo_rst),
        .push  (w_push_req),
        .din   (w_din),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .level (trace_level)
    );

    assign trace_valid = ~w_empty;
    assign trace_pc    = w_head.pc;
    assign trace_rd    = w_head.rd;
    assign trace_data  = w_head.data;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cycle_count   <= '0;
            r_instret_count <= '0;
            r_stall_count   <= '0;
            r_flush_count   <= '0;
            r_overflow      <= 1'b0;
            r_drop_count    <= '0;
        end else begin
            if (enable) begin
                r_cycle_count <= r_cycle_count + 1'b1;
                if (wb_valid) begin
                    r_instret_count <= r_instret_count + 1'b1;
                end
                if (stall_f | stall_d) begin
                    r_stall_count <= r_stall_count + 1'b1;
                end
                if (flush_d | flush_e) begin
                    r_flush_count <= r_flush_count + 1'b1;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != '1) begin
                    r_drop_count <= r_drop_count + 1'b1;
                end
            end
        end
    end

    assign cycle_count   = r_cycle_count;
    assign instret_count = r_instret_count;
    assign stall_count   = r_stall_count;
    assign flush_count   = r_flush_count;
    assign overflow      = r_overflow;
    assign drop_count    = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_pipe_perf_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_perf_trace_monitor
// Description : Self-checking bench: default instance plus a small instance
//               (4-bit counters, 2-deep FIFO, 2-bit drop counter).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_perf_trace_monitor;

    logic        clk = 1'b0;
    logic        rst, enable, clear, stall_f, stall_d, flush_d, flush_e;
    logic        wb_valid, wb_regwrite, trace_ready;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data, wb_pc;

    logic [31:0] a_cyc, a_ins, a_stl, a_fls, a_tpc, a_tdata;
    logic        a_tv, a_ovf;
    logic [4:0]  a_trd;
    logic [3:0]  a_lvl;
    logic [15:0] a_drop;

    logic [3:0]  b_cyc, b_ins, b_stl, b_fls;
    logic [31:0] b_tpc, b_tdata;
    logic        b_tv, b_ovf;
    logic [4:0]  b_trd;
    logic [1:0]  b_lvl;
    logic [1:0]  b_drop;

    always #5 clk = ~clk;

    pipe_perf_trace_monitor dut (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc),
        .cycle_count(a_cyc), .instret_count(a_ins), .stall_count(a_stl), .flush_count(a_fls),
        .trace_valid(a_tv), .trace_ready(trace_ready), .trace_pc(a_tpc), .trace_rd(a_trd),
        .trace_data(a_tdata), .trace_level(a_lvl), .overflow(a_ovf), .drop_count(a_drop)
    );

    pipe_perf_trace_monitor #(.COUNT_W(4), .FIFO_DEPTH(2), .DROP_W(2)) dut4 (
        .clk(clk), .rst(rst), .enable(enable), .clear(clear),
        .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc),
        .cycle_count(b_cyc), .instret_count(b_ins), .stall_count(b_stl), .flush_count(b_fls),
        .trace_valid(b_tv), .trace_ready(trace_ready), .trace_pc(b_tpc), .trace_rd(b_trd),
        .trace_data(b_tdata), .trace_level(b_lvl), .overflow(b_ovf), .drop_count(b_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counters as plain integers, FIFO as a queue of {pc,rd,data}.
    logic [68:0]     q0[$];
    logic [68:0]     q1[$];
    longint unsigned m_cyc[2], m_ins[2], m_stl[2], m_fls[2], m_drop[2];
    bit              m_ovf[2];

    function automatic longint unsigned wrap_inc(input longint unsigned v, input int w);
        return (v + 1) % (64'd1 << w);
    endfunction

    task automatic model_step(input int k);
        int  depth, cw, dw, sz;
        bit  pop, push;
        depth = (k == 0) ? 8 : 2;
        cw    = (k == 0) ? 32 : 4;
        dw    = (k == 0) ? 16 : 2;
        sz    = (k == 0) ? q0.size() : q1.size();
        if (rst || clear) begin
            m_cyc[k] = 0; m_ins[k] = 0; m_stl[k] = 0; m_fls[k] = 0;
            m_drop[k] = 0; m_ovf[k] = 0;
            if (k == 0) q0.delete(); else q1.delete();
            return;
        end
        if (enable) begin
            m_cyc[k] = wrap_inc(m_cyc[k], cw);
            if (wb_valid)           m_ins[k] = wrap_inc(m_ins[k], cw);
            if (stall_f || stall_d) m_stl[k] = wrap_inc(m_stl[k], cw);
            if (flush_d || flush_e) m_fls[k] = wrap_inc(m_fls[k], cw);
        end
        pop  = (sz > 0) && trace_ready;
        push = enable && wb_valid && wb_regwrite && (wb_rd != 5'd0);
        if (pop) begin
            if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            sz--;
        end
        if (push) begin
            if (sz < depth) begin
                if (k == 0) q0.push_back({wb_pc, wb_rd, wb_data});
                else        q1.push_back({wb_pc, wb_rd, wb_data});
            end else begin
                m_ovf[k] = 1;
                if (m_drop[k] < (64'd1 << dw) - 1) m_drop[k]++;
            end
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic compare_all();
        logic [68:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 69'd0;
        h1 = (q1.size() > 0) ? q1[0] : 69'd0;
        chk("a.cycle_count",   64'(a_cyc),   m_cyc[0]);
        chk("a.instret_count", 64'(a_ins),   m_ins[0]);
        chk("a.stall_count",   64'(a_stl),   m_stl[0]);
        chk("a.flush_count",   64'(a_fls),   m_fls[0]);
        chk("a.trace_valid",   64'(a_tv),    64'(q0.size() > 0));
        chk("a.trace_level",   64'(a_lvl),   64'(q0.size()));
        chk("a.trace_pc",      64'(a_tpc),   64'(h0[68:37]));
        chk("a.trace_rd",      64'(a_trd),   64'(h0[36:32]));
        chk("a.trace_data",    64'(a_tdata), 64'(h0[31:0]));
        chk("a.overflow",      64'(a_ovf),   64'(m_ovf[0]));
        chk("a.drop_count",    64'(a_drop),  m_drop[0]);
        chk("b.cycle_count",   64'(b_cyc),   m_cyc[1]);
        chk("b.instret_count", 64'(b_ins),   m_ins[1]);
        chk("b.stall_count",   64'(b_stl),   m_stl[1]);
        chk("b.flush_count",   64'(b_fls),   m_fls[1]);
        chk("b.trace_valid",   64'(b_tv),    64'(q1.size() > 0));
        chk("b.trace_level",   64'(b_lvl),   64'(q1.size()));
        chk("b.trace_pc",      64'(b_tpc),   64'(h1[68:37]));
        chk("b.trace_rd",      64'(b_trd),   64'(h1[36:32]));
        chk("b.trace_data",    64'(b_tdata), 64'(h1[31:0]));
        chk("b.overflow",      64'(b_ovf),   64'(m_ovf[1]));
        chk("b.drop_count",    64'(b_drop),  m_drop[1]);
    endtask

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            compare_all();
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_pc = pc; wb_rd = rd; wb_data = data;
        tick();
        wb_valid = 1'b0; wb_regwrite = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0;
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
        wb_valid = 1'b0; wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = '0; wb_pc = '0;
        trace_ready = 1'b0;

        // Reset, then 10 enabled cycles, then clear.
        tick(); tick();
        chk("lit.reset_cycle", 64'(a_cyc), 64'd0);
        chk("lit.reset_valid", 64'(a_tv),  64'd0);
        chk("lit.reset_level", 64'(a_lvl), 64'd0);
        rst = 1'b0; enable = 1'b1;
        repeat (10) tick();
        chk("lit.cycle_10", 64'(a_cyc), 64'd10);
        pulse_clear();
        chk("lit.clear_cycle", 64'(a_cyc),  64'd0);
        chk("lit.clear_drop",  64'(a_drop), 64'd0);

        // Trace ordering; x0 write is never traced.
        retire(32'h00, 5'd5, 32'h11);
        retire(32'h04, 5'd0, 32'h22);
        retire(32'h08, 5'd6, 32'h33);
        chk("lit.order_level",   64'(a_lvl),   64'd2);
        chk("lit.order_instret", 64'(a_ins),   64'd3);
        chk("lit.order_head_rd", 64'(a_trd),   64'd5);
        chk("lit.order_head_dt", 64'(a_tdata), 64'h11);
        trace_ready = 1'b1;
        tick();
        chk("lit.order_2nd_pc", 64'(a_tpc),   64'h08);
        chk("lit.order_2nd_rd", 64'(a_trd),   64'd6);
        chk("lit.order_2nd_dt", 64'(a_tdata), 64'h33);
        tick();
        chk("lit.order_empty", 64'(a_tv), 64'd0);
        trace_ready = 1'b0;

        // Overflow: 10 pushes into 8 slots; small instance saturates drop at 3.
        for (int i = 0; i < 10; i++) retire(32'h100 + 32'(4 * i), 5'(i + 1), 32'hA0 + 32'(i));
        chk("lit.ovf_level",   64'(a_lvl),  64'd8);
        chk("lit.ovf_flag",    64'(a_ovf),  64'd1);
        chk("lit.ovf_drop",    64'(a_drop), 64'd2);
        chk("lit.ovf_head",    64'(a_tpc),  64'h100);
        chk("lit.ovf_b_drop",  64'(b_drop), 64'd3);

        // Full FIFO: push and pop together drop nothing.
        pulse_clear();
        for (int i = 0; i < 8; i++) retire(32'h200 + 32'(4 * i), 5'(i + 1), 32'hB0 + 32'(i));
        trace_ready = 1'b1;
        retire(32'h300, 5'd9, 32'hCC);
        chk("lit.fpp_level", 64'(a_lvl),  64'd8);
        chk("lit.fpp_ovf",   64'(a_ovf),  64'd0);
        chk("lit.fpp_head",  64'(a_tpc),  64'h204);
        repeat (7) tick();
        chk("lit.fpp_tail",  64'(a_tpc),  64'h300);
        chk("lit.fpp_lvl1",  64'(a_lvl),  64'd1);
        repeat (2) tick();
        trace_ready = 1'b0;

        // Hazard counting over 20 cycles, then overlapping flushes.
        pulse_clear();
        for (int c = 1; c <= 23; c++) begin
            stall_f = (c >= 3 && c <= 5);
            stall_d = (c == 5 || c == 6);
            flush_e = (c == 6 || c == 22);
            flush_d = (c == 21 || c == 22);
            tick();
            if (c == 20) begin
                chk("lit.haz_stall", 64'(a_stl), 64'd4);
                chk("lit.haz_flush", 64'(a_fls), 64'd1);
            end
        end
        stall_f = 1'b0; stall_d = 1'b0; flush_e = 1'b0; flush_d = 1'b0;
        chk("lit.haz_flush2", 64'(a_fls), 64'd3);

        // Enable gating and 4-bit wrap; pops continue while disabled.
        pulse_clear();
        retire(32'h400, 5'd3, 32'h1);
        retire(32'h404, 5'd4, 32'h2);
        repeat (15) tick();
        chk("lit.wrap_b_cyc", 64'(b_cyc), 64'd1);
        chk("lit.wrap_a_cyc", 64'(a_cyc), 64'd17);
        enable = 1'b0; trace_ready = 1'b1;
        wb_valid = 1'b1; wb_regwrite = 1'b1; wb_rd = 5'd7; stall_f = 1'b1; flush_d = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("lit.gate_b_cyc", 64'(b_cyc), 64'd1);
        end
        chk("lit.gate_ins",   64'(a_ins), 64'd2);
        chk("lit.gate_stall", 64'(a_stl), 64'd0);
        chk("lit.gate_level", 64'(a_lvl), 64'd0);
        wb_valid = 1'b0; wb_regwrite = 1'b0; stall_f = 1'b0; flush_d = 1'b0;
        trace_ready = 1'b0; enable = 1'b1;

        // Reset in the middle of a drain.
        retire(32'h500, 5'd1, 32'h5);
        retire(32'h504, 5'd2, 32'h6);
        retire(32'h508, 5'd3, 32'h7);
        trace_ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk("lit.rst_drain_valid", 64'(a_tv),  64'd0);
        chk("lit.rst_drain_level", 64'(a_lvl), 64'd0);
        chk("lit.rst_drain_pc",    64'(a_tpc), 64'd0);
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_perf_trace_monitor.md
Name: pipe_perf_trace_monitor

Overview:
- Passive observer attached to the writeback and hazard signals of the pipelined RISC-V core.
- Counts cycles, retired instructions, stall cycles and flush events.
- Captures every architectural register write (pc, rd, data) into a small trace FIFO that the bench or a debug port drains through a valid/ready handshake.
- Sits downstream of Pipelined_Processor_Top and never drives the core.

Parameters:
COUNT_W, 32, width of each performance counter (wraps modulo 2^COUNT_W)
FIFO_DEPTH, 8, trace FIFO entries; must be a power of two, at least 2
DROP_W, 16, width of the dropped-trace counter (saturates)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  counting and trace capture allowed when 1
clear  in  1  synchronous clear of counters, FIFO and flags
stall_f  in  1  fetch stall from hazard unit
stall_d  in  1  decode stall from hazard unit
flush_d  in  1  decode flush
flush_e  in  1  execute flush
wb_valid  in  1  an instruction retires this cycle
wb_regwrite  in  1  retiring instruction writes the register file
wb_rd  in  5  destination register
wb_data  in  32  Result_W value
wb_pc  in  32  PC of the retiring instruction
cycle_count  out  COUNT_W  enabled cycles
instret_count  out  COUNT_W  retired instructions
stall_count  out  COUNT_W  cycles with stall_f or stall_d high
flush_count  out  COUNT_W  cycles with flush_d or flush_e high
trace_valid  out  1  FIFO head entry is valid
trace_ready  in  1  consumer accepts the head entry
trace_pc  out  32  head entry PC
trace_rd  out  5  head entry rd
trace_data  out  32  head entry data
trace_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky; a trace entry was dropped
drop_count  out  DROP_W  number of dropped entries, saturating

Behaviour:
- Reset: every output is 0 and the FIFO is empty (trace_valid=0, trace_pc/rd/data=0, trace_level=0).
- Priority: rst, then clear, then normal operation. clear has the same effect as rst. An event that coincides with clear is not counted.
- Counter updates are registered and visible the cycle after the event.
  - cycle_count increments on every cycle with enable=1.
  - instret_count increments on enable & wb_valid.
  - stall_count increments on enable & (stall_f | stall_d), at most once per cycle.
  - flush_count increments on enable & (flush_d | flush_e), at most once per cycle.
  - All four counters wrap from all-ones to 0 without raising any flag.
- Push condition: enable & wb_valid & wb_regwrite & (wb_rd != 0). Writes to x0 are never traced.
- Pop condition: trace_valid & trace_ready.
- FIFO is first-word-fall-through. The head entry appears on trace_* the cycle after the push into an empty FIFO. The trace_* outputs must be 0 while empty.
- Push and pop in the same cycle:
  - When non-empty, both occur and the level is unchanged.
  - When empty, only the push occurs; there is no combinational bypass.
- Push while full with no pop: the new entry is discarded, FIFO contents are unchanged, overflow is set to 1, and drop_count increments and saturates at all-ones.
- Push while full with a pop in the same cycle: both occur and nothing is dropped.
- Pop while empty is ignored.
- Read and write pointers wrap modulo FIFO_DEPTH. trace_level ranges from 0 to FIFO_DEPTH.
- enable=0 freezes counters and capture, but pops still proceed.
- rst or clear asserted mid-drain empties the FIFO immediately and sets trace_valid=0 on the next cycle.

Decomposition:
- Package pipe_perf_pkg holds:
  - the trace_entry_t struct {pc[31:0], rd[4:0], data[31:0]};
  - TRACE_W = 69;
  - the default COUNT_W, FIFO_DEPTH and DROP_W constants.
- Sub-module perf_trace_fifo: a synchronous FWFT FIFO parameterised on width and depth, with push, pop, full, empty and level.
- Counters and drop logic stay in the top module.

Test Plan:
- Reset and clear: hold rst for 2 cycles, then enable=1 for 10 cycles, then pulse clear. Require cycle_count=10 before the clear and all outputs 0 in the cycle after it.
- Trace order: retire (pc 0x00, x5, 0x11), (0x04, x0, 0x22), (0x08, x6, 0x33) with trace_ready=0. Require trace_level=2. Then drain with trace_ready=1: entries appear as (0x00,5,0x11) then (0x08,6,0x33). Require instret_count=3.
- Overflow: push 10 entries with trace_ready=0 and FIFO_DEPTH=8. Require trace_level=8, overflow=1, drop_count=2, and the head is still the first entry.
- Full push plus pop: with the FIFO full, assert a push and trace_ready=1 in the same cycle. Require trace_level to stay 8, overflow to stay 0, and the new entry to be at the tail.
- Hazard counting: over 20 cycles, stall_f=1 on cycles 3–5, stall_d=1 on cycles 5–6, flush_e=1 on cycle 6. Require stall_count=4 and flush_count=1.
- Enable gating and wrap: with COUNT_W=4, run 17 enabled cycles, then hold enable=0 for 5 cycles. Require cycle_count=1, unchanged during the 5 disabled cycles.
